// File: rtl/serial_paralelo_rx_if.sv
// Serial receive link bundle: raw serial line in, aligned byte stream and link status out.
// The slave modport is the deserializer side; master is the upstream driver / downstream consumer.
interface serial_paralelo_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Bit-rate deserializer with COMMA bit-slip alignment and sync counting for phy_rx.
// Optional SYNC_LOSS_EN: drops sync after LOSS_COUNT consecutive stuck (00/FF) bytes.
module serial_paralelo_rx #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         BC_COUNT = 4
`ifdef SYNC_LOSS_EN
    , parameter int       LOSS_COUNT = 4
`endif
) (
    input logic                  clk_32f,
    input logic                  reset_L,
    serial_paralelo_rx_if.slave  rx
);
    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

    localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

    state_t     state, state_nx;
    logic [7:0] sr;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [3:0] bc_cnt, bc_cnt_nx;
    logic [7:0] data_q, data_nx;
    logic       valid_q, valid_nx;
    logic       active_q, active_nx;
    logic       boundary;
    logic       is_comma;

    assign boundary = (state != SEARCH) && (bit_cnt == 3'd0);
    assign is_comma = (sr == COMMA);

`ifdef SYNC_LOSS_EN
    localparam logic [3:0] LOSS_TARGET = 4'(LOSS_COUNT);
    logic [3:0] loss_cnt, loss_nx;
    logic       stuck;
    assign stuck = (sr == 8'h00) || (sr == 8'hFF);
`endif

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt + 3'd1;
        bc_cnt_nx  = bc_cnt;
        data_nx    = data_q;
        valid_nx   = 1'b0;
        active_nx  = active_q;
`ifdef SYNC_LOSS_EN
        loss_nx    = loss_cnt;
`endif
        case (state)
            SEARCH: begin
                // Matching here fixes the phase: bit_cnt returns to 0 exactly 8 cycles later.
                bit_cnt_nx = 3'd0;
                if (is_comma) begin
                    bit_cnt_nx = 3'd1;
                    bc_cnt_nx  = 4'd1;
                    state_nx   = ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        if (bc_cnt + 4'd1 == BC_TARGET) begin
                            state_nx  = ACTIVE;
                            active_nx = 1'b1;
                        end else begin
                            bc_cnt_nx = bc_cnt + 4'd1;
                        end
                    end else begin
                        state_nx   = SEARCH;
                        bc_cnt_nx  = 4'd0;
                        bit_cnt_nx = 3'd0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_nx  = sr;
                    valid_nx = !is_comma;
`ifdef SYNC_LOSS_EN
                    if (stuck) begin
                        if (loss_cnt >= LOSS_TARGET - 4'd1) begin
                            data_nx    = data_q;
                            valid_nx   = 1'b0;
                            active_nx  = 1'b0;
                            state_nx   = SEARCH;
                            bc_cnt_nx  = 4'd0;
                            bit_cnt_nx = 3'd0;
                            loss_nx    = 4'd0;
                        end else if (loss_cnt != 4'hF) begin
                            loss_nx = loss_cnt + 4'd1;
                        end
                    end else begin
                        loss_nx = 4'd0;
                    end
`endif
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state    <= SEARCH;
            sr       <= 8'h00;
            bit_cnt  <= 3'd0;
            bc_cnt   <= 4'd0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
`ifdef SYNC_LOSS_EN
            loss_cnt <= 4'd0;
`endif
        end else begin
            state    <= state_nx;
            sr       <= {sr[6:0], rx.data_in};
            bit_cnt  <= bit_cnt_nx;
            bc_cnt   <= bc_cnt_nx;
            data_q   <= data_nx;
            valid_q  <= valid_nx;
            active_q <= active_nx;
`ifdef SYNC_LOSS_EN
            loss_cnt <= loss_nx;
`endif
        end
    end

    assign rx.data_out  = data_q;
    assign rx.valid_out = valid_q;
    assign rx.active    = active_q;
endmodule
